// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master bit engine: command codes, FSM states,
// phase-length selection and per-state line drive values.
package i2c_pkg;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_START = 3'd1,
      CMD_STOP  = 3'd2,
      CMD_WRITE = 3'd3,
      CMD_READ  = 3'd4
   } cmd_e;

   typedef enum logic [3:0] {
      IDLE, STA_A, STA_B, STA_C, STA_D,
      STO_A, STO_B, STO_C,
      WR_A, WR_B, WR_C,
      RD_A, RD_B, RD_C
   } state_e;

   typedef enum logic [3:0] {
      PH_NONE, PH_HALF_LOW, PH_SUSTA, PH_HDSTA, PH_SUSTO,
      PH_BUF, PH_SUDAT, PH_HDDAT, PH_HIGH
   } phase_e;

   function automatic phase_e state_phase(input state_e s);
      case (s)
         STA_A, STA_D, RD_A, RD_C: return PH_HALF_LOW;
         STA_B:                    return PH_SUSTA;
         STA_C:                    return PH_HDSTA;
         STO_A, WR_A:              return PH_SUDAT;
         STO_B:                    return PH_SUSTO;
         STO_C:                    return PH_BUF;
         WR_B, RD_B:               return PH_HIGH;
         WR_C:                     return PH_HDDAT;
         default:                  return PH_NONE;
      endcase
   endfunction

   // States in which SCL is released and a slave may stretch it.
   function automatic logic scl_high_phase(input state_e s);
      return (s == STA_B) || (s == STA_C) || (s == STO_B) || (s == WR_B) || (s == RD_B);
   endfunction

   // Returns {scl, sda}; STA_A keeps SCL where it is, IDLE keeps both lines.
   function automatic logic [1:0] line_drive(input state_e s, input logic wbit, input logic [1:0] cur);
      case (s)
         STA_A:   return {cur[1], 1'b1};
         STA_B:   return 2'b11;
         STA_C:   return 2'b10;
         STA_D:   return 2'b00;
         STO_A:   return 2'b00;
         STO_B:   return 2'b10;
         STO_C:   return 2'b11;
         WR_A:    return {1'b0, wbit};
         WR_B:    return {1'b1, wbit};
         WR_C:    return {1'b0, wbit};
         RD_A:    return 2'b01;
         RD_B:    return 2'b11;
         RD_C:    return 2'b01;
         default: return cur;
      endcase
   endfunction

endpackage

// File: rtl/i2c_phy_timer.sv
// Phase counter and SCL-stretch counter for the I2C bit engine; both saturate
// and clear whenever the FSM changes state.
module i2c_phy_timer #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned STRETCH_W = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 clr,
   input  logic                 stretch,
   input  logic [CNT_W-1:0]     limit,
   input  logic [STRETCH_W-1:0] stretch_max,
   output logic [CNT_W-1:0]     cnt,
   output logic                 phase_done,
   output logic                 stretch_hit
);

   logic [STRETCH_W-1:0] scnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         scnt <= '0;
      end else if (ena) begin
         if (clr) begin
            cnt  <= '0;
            scnt <= '0;
         end else if (stretch) begin
            if (scnt != '1) scnt <= scnt + 1'b1;
         end else begin
            scnt <= '0;
            if (cnt != '1) cnt <= cnt + 1'b1;
         end
      end
   end

   // A stretched cycle never ends a phase; the limit counts the current stretched cycle.
   assign phase_done  = !stretch && (cnt >= limit);
   assign stretch_hit = stretch && (stretch_max != '0) &&
                        (({1'b0, scnt} + 1'b1) >= {1'b0, stretch_max});

endmodule

// File: rtl/i2c_phy_engine.sv
// I2C master bit engine: executes one START/STOP/WRITE/READ bit command as
// timed SCL/SDA phases, with stretch timeout, arbitration and bus ownership.
module i2c_phy_engine
   import i2c_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned STRETCH_W = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd,
   input  logic                 din,
   output logic                 cmd_done,
   output logic                 dout,
   output logic                 al,
   output logic                 timeout,
   output logic                 bus_owned,
   input  logic [CNT_W-1:0]     tsusta,
   input  logic [CNT_W-1:0]     thdsta,
   input  logic [CNT_W-1:0]     tsusto,
   input  logic [CNT_W-1:0]     tsudat,
   input  logic [CNT_W-1:0]     thddat,
   input  logic [CNT_W-1:0]     tlow,
   input  logic [CNT_W-1:0]     thigh,
   input  logic [CNT_W-1:0]     tbuf,
   input  logic [STRETCH_W-1:0] stretch_max,
   input  logic                 sto_det,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 scl_o,
   output logic                 sda_o
);

   state_e           state, nxt;
   logic             din_q;
   logic [CNT_W-1:0] half_low, limit, cnt;
   logic             accept, stretch, phase_done, stretch_hit;
   logic             lost, abort, clr, done_evt, rd_sample;

   assign cmd_ready = ena && (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign half_low  = (tlow >> 1) + CNT_W'(tlow[0]);
   assign stretch   = scl_high_phase(state) && scl_o && !scl_i;
   // The counter holds at 0 while stretched, so this fires once per READ.
   assign rd_sample = (state == RD_B) && scl_i && (cnt == '0);

   always_comb begin
      limit = '0;
      case (state_phase(state))
         PH_HALF_LOW: limit = half_low;
         PH_SUSTA:    limit = tsusta;
         PH_HDSTA:    limit = thdsta;
         PH_SUSTO:    limit = tsusto;
         PH_BUF:      limit = tbuf;
         PH_SUDAT:    limit = tsudat;
         PH_HDDAT:    limit = thddat;
         PH_HIGH:     limit = thigh;
         default:     limit = '0;
      endcase
   end

   i2c_phy_timer #(
      .CNT_W     (CNT_W),
      .STRETCH_W (STRETCH_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .clr         (clr),
      .stretch     (stretch),
      .limit       (limit),
      .stretch_max (stretch_max),
      .cnt         (cnt),
      .phase_done  (phase_done),
      .stretch_hit (stretch_hit)
   );

   always_comb begin
      lost = (((state == STA_B) || ((state == WR_B) && phase_done)) && sda_o && !sda_i) ||
             (sto_det && bus_owned && !(state inside {STO_A, STO_B, STO_C}));
      abort = lost || stretch_hit;
      nxt   = state;
      if (abort) begin
         nxt = IDLE;
      end else if (state == IDLE) begin
         if (accept) begin
            case (cmd_e'(cmd))
               CMD_START: nxt = bus_owned ? STA_A : STA_B;
               CMD_STOP:  nxt = STO_A;
               CMD_WRITE: nxt = WR_A;
               CMD_READ:  nxt = RD_A;
               default:   nxt = IDLE;
            endcase
         end
      end else if (phase_done) begin
         case (state)
            STA_A:   nxt = STA_B;
            STA_B:   nxt = STA_C;
            STA_C:   nxt = STA_D;
            STO_A:   nxt = STO_B;
            STO_B:   nxt = STO_C;
            WR_A:    nxt = WR_B;
            WR_B:    nxt = WR_C;
            RD_A:    nxt = RD_B;
            RD_B:    nxt = RD_C;
            default: nxt = IDLE;
         endcase
      end
      done_evt = !abort && phase_done && (state inside {STA_D, STO_C, WR_C, RD_C});
      clr      = (nxt != state);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         scl_o     <= 1'b1;
         sda_o     <= 1'b1;
         din_q     <= 1'b0;
         dout      <= 1'b0;
         cmd_done  <= 1'b0;
         al        <= 1'b0;
         timeout   <= 1'b0;
         bus_owned <= 1'b0;
      end else if (ena) begin
         state    <= nxt;
         cmd_done <= done_evt;
         al       <= lost;
         timeout  <= stretch_hit;
         if (accept) din_q <= din;
         if (rd_sample) dout <= sda_i;
         if (abort) begin
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            bus_owned <= 1'b0;
         end else begin
            if (clr) {scl_o, sda_o} <= line_drive(nxt, accept ? din : din_q, {scl_o, sda_o});
            if (done_evt && (state == STA_D)) bus_owned <= 1'b1;
            else if (done_evt && (state == STO_C)) bus_owned <= 1'b0;
         end
      end else begin
         cmd_done <= 1'b0;
         al       <= 1'b0;
         timeout  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2c_phy_engine.sv
// Bench for i2c_phy_engine: each command's SCL/SDA waveform is compared, as
// run-length segments, against the phase table built from the timing inputs.
module tb_i2c_phy_engine;
   import i2c_pkg::*;

   localparam int CW = 16;
   localparam int SW = 20;

   logic          clk = 1'b0;
   logic          rst, ena, cmd_valid, cmd_ready, din, cmd_done, dout;
   logic          al, timeout, bus_owned, sto_det, scl_i, sda_i, scl_o, sda_o;
   logic [2:0]    cmd;
   logic [CW-1:0] tsusta, thdsta, tsusto, tsudat, thddat, tlow, thigh, tbuf;
   logic [SW-1:0] stretch_max;
   logic          scl_hold, slave_sda, other_sda;

   assign scl_i = scl_o & ~scl_hold;
   assign sda_i = sda_o & slave_sda & other_sda;

   always #5 clk = ~clk;

   i2c_phy_engine #(.CNT_W(CW), .STRETCH_W(SW)) dut (
      .clk(clk), .rst(rst), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .din(din), .cmd_done(cmd_done), .dout(dout), .al(al), .timeout(timeout),
      .bus_owned(bus_owned), .tsusta(tsusta), .thdsta(thdsta), .tsusto(tsusto),
      .tsudat(tsudat), .thddat(thddat), .tlow(tlow), .thigh(thigh), .tbuf(tbuf),
      .stretch_max(stretch_max), .sto_det(sto_det), .scl_i(scl_i), .sda_i(sda_i),
      .scl_o(scl_o), .sda_o(sda_o)
   );

   typedef struct packed {
      logic        scl;
      logic        sda;
      logic [31:0] len;
   } seg_t;

   int   n_checks = 0;
   int   n_errors = 0;
   seg_t exp_q[$];
   seg_t obs_q[$];
   logic m_scl;
   logic m_owned;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic s, input logic d, input int unsigned len);
      seg_t t;
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1].scl == s && exp_q[exp_q.size()-1].sda == d) begin
         t = exp_q[exp_q.size()-1];
         t.len = t.len + len;
         exp_q[exp_q.size()-1] = t;
      end else begin
         t.scl = s; t.sda = d; t.len = len;
         exp_q.push_back(t);
      end
   endtask

   task automatic push_obs(input logic s, input logic d);
      seg_t t;
      if (obs_q.size() > 0 && obs_q[obs_q.size()-1].scl == s && obs_q[obs_q.size()-1].sda == d) begin
         t = obs_q[obs_q.size()-1];
         t.len = t.len + 1;
         obs_q[obs_q.size()-1] = t;
      end else begin
         t.scl = s; t.sda = d; t.len = 1;
         obs_q.push_back(t);
      end
   endtask

   function automatic int unsigned ceil_half(input logic [CW-1:0] v);
      return (32'(v) + 1) / 2;
   endfunction

   // Expected waveform: every phase lasts its programmed value + 1 cycles.
   task automatic build_exp(input cmd_e c, input logic d, input int unsigned ext, input int unsigned gap);
      int unsigned h;
      h = ceil_half(tlow);
      exp_q.delete();
      case (c)
         CMD_START: begin
            if (m_owned) push_exp(m_scl, 1'b1, h + 1);
            push_exp(1'b1, 1'b1, 32'(tsusta) + 1 + gap);
            push_exp(1'b1, 1'b0, 32'(thdsta) + 1);
            push_exp(1'b0, 1'b0, h + 1);
         end
         CMD_STOP: begin
            push_exp(1'b0, 1'b0, 32'(tsudat) + 1);
            push_exp(1'b1, 1'b0, 32'(tsusto) + 1);
            push_exp(1'b1, 1'b1, 32'(tbuf) + 1);
         end
         CMD_WRITE: begin
            push_exp(1'b0, d, 32'(tsudat) + 1);
            push_exp(1'b1, d, 32'(thigh) + 1 + ext);
            push_exp(1'b0, d, 32'(thddat) + 1);
         end
         default: begin
            push_exp(1'b0, 1'b1, h + 1);
            push_exp(1'b1, 1'b1, 32'(thigh) + 1 + ext);
            push_exp(1'b0, 1'b1, h + 1);
         end
      endcase
   endtask

   // d is the write bit, or the bit the slave returns for READ; ext = SCL stretch
   // cycles applied by the slave; gap = ena-low cycles inserted early in STA_B.
   task automatic run_cmd(input cmd_e c, input logic d, input int unsigned ext, input int unsigned gap);
      int unsigned hold_cnt;
      logic        seen_done;
      int          nmin;
      build_exp(c, d, ext, gap);
      scl_hold  = (ext > 0);
      slave_sda = (c == CMD_READ) ? d : 1'b1;
      chk({c.name(), "_ready"}, cmd_ready, 1);
      cmd = c; din = d; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      obs_q.delete();
      seen_done = 1'b0;
      hold_cnt  = 0;
      for (int i = 0; i < 5000; i++) begin
         if (cmd_done) begin
            seen_done = 1'b1;
            break;
         end
         push_obs(scl_o, sda_o);
         if (scl_hold && scl_o) begin
            hold_cnt++;
            if (hold_cnt == ext + 1) scl_hold = 1'b0;
         end
         if (gap > 0 && obs_q.size() == 1 && obs_q[0].len == 3) begin
            ena = 1'b0;
            repeat (gap) begin
               tick();
               push_obs(scl_o, sda_o);
            end
            ena = 1'b1;
         end
         tick();
      end
      scl_hold  = 1'b0;
      slave_sda = 1'b1;
      chk({c.name(), "_done_seen"}, seen_done, 1);
      chk({c.name(), "_ready_at_done"}, cmd_ready, 1);
      chk({c.name(), "_nseg"}, obs_q.size(), exp_q.size());
      nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++)
         chk($sformatf("%s_seg%0d", c.name(), i), obs_q[i], exp_q[i]);
      m_scl = exp_q[exp_q.size()-1].scl;
      if (c == CMD_START) m_owned = 1'b1;
      if (c == CMD_STOP)  m_owned = 1'b0;
      chk({c.name(), "_bus_owned"}, bus_owned, m_owned);
      chk({c.name(), "_no_abort"}, {al, timeout}, 0);
      if (c == CMD_READ) chk("read_dout", dout, d);
   endtask

   task automatic issue(input cmd_e c, input logic d);
      cmd = c; din = d; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        got;
      logic [7:0]  byte_v;
      rst = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd = '0; din = 1'b0; sto_det = 1'b0;
      scl_hold = 1'b0; slave_sda = 1'b1; other_sda = 1'b1;
      tlow = 10; thigh = 8; tsusta = 4; thdsta = 4; tsusto = 4; tsudat = 4; thddat = 4; tbuf = 4;
      stretch_max = '0;
      m_scl = 1'b1; m_owned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {scl_o, sda_o, cmd_ready, cmd_done, dout, al, timeout, bus_owned}, 8'b1110_0000);
      rst = 1'b0;
      tick();

      // NOP is accepted and leaves everything untouched
      issue(CMD_NOP, 1'b0);
      chk("nop", {cmd_ready, scl_o, sda_o, cmd_done, bus_owned}, 5'b11100);
      tick();
      chk("nop_later", {cmd_ready, cmd_done}, 2'b10);

      // 1: START, 0xA5, READ, STOP
      byte_v = 8'hA5;
      run_cmd(CMD_START, 1'b0, 0, 0);
      for (int i = 7; i >= 0; i--) run_cmd(CMD_WRITE, byte_v[i], 0, 0);
      run_cmd(CMD_READ, 1'b1, 0, 0);
      run_cmd(CMD_STOP, 1'b0, 0, 0);

      // 2: slave returns 0 and stretches SCL 50 cycles, timeout disabled
      run_cmd(CMD_START, 1'b0, 0, 0);
      run_cmd(CMD_READ, 1'b0, 50, 0);
      run_cmd(CMD_STOP, 1'b0, 0, 0);

      // 3: stretch timeout during WR_B
      run_cmd(CMD_START, 1'b0, 0, 0);
      stretch_max = 100;
      scl_hold = 1'b1;
      issue(CMD_WRITE, 1'b0);
      n = 0; got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (timeout || al || cmd_done) begin got = 1'b1; break; end
         if (scl_o) n++;
         tick();
      end
      chk("to_seen", got, 1);
      chk("to_cycle", n, 100);
      chk("to_state", {timeout, al, cmd_done, scl_o, sda_o, bus_owned, cmd_ready}, 7'b1001101);
      scl_hold = 1'b0;
      tick();
      chk("to_pulse", timeout, 0);
      stretch_max = '0; m_scl = 1'b1; m_owned = 1'b0;

      // 4: another master pulls SDA low while we send a 1
      run_cmd(CMD_START, 1'b0, 0, 0);
      issue(CMD_WRITE, 1'b1);
      n = 0; got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (al || timeout || cmd_done) begin got = 1'b1; break; end
         if (scl_o) begin n++; other_sda = 1'b0; end
         tick();
      end
      chk("al_seen", got, 1);
      chk("al_cycle", n, 32'(thigh) + 1);
      chk("al_state", {al, timeout, cmd_done, scl_o, sda_o, bus_owned, cmd_ready}, 7'b1001101);
      other_sda = 1'b1;
      tick();
      chk("al_pulse", al, 0);
      m_scl = 1'b1; m_owned = 1'b0;

      // 5: repeated start, then a foreign STOP mid-WRITE
      run_cmd(CMD_START, 1'b0, 0, 0);
      run_cmd(CMD_WRITE, 1'b1, 0, 0);
      run_cmd(CMD_START, 1'b0, 0, 0);
      issue(CMD_WRITE, 1'b0);
      tick();
      sto_det = 1'b1;
      tick();
      sto_det = 1'b0;
      chk("sto_al", {al, cmd_done, scl_o, sda_o, bus_owned}, 5'b10110);
      tick();
      chk("sto_al_pulse", al, 0);
      m_scl = 1'b1; m_owned = 1'b0;

      // 6a: asynchronous reset in a very long WR_B
      run_cmd(CMD_START, 1'b0, 0, 0);
      thigh = 16'hFFFF;
      issue(CMD_WRITE, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (scl_o) begin got = 1'b1; break; end
         tick();
      end
      chk("wrb_reached", got, 1);
      repeat (3) tick();
      chk("pre_rst_lines", {scl_o, sda_o}, 2'b10);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {scl_o, sda_o, bus_owned, cmd_ready, cmd_done}, 5'b11010);
      tick();
      rst = 1'b0;
      thigh = 8;
      tick();
      m_scl = 1'b1; m_owned = 1'b0;

      // 6b: ena low for 20 cycles inside STA_B
      tsusta = 10;
      run_cmd(CMD_START, 1'b0, 0, 20);
      run_cmd(CMD_STOP, 1'b0, 0, 0);

      // randomized transactions
      for (int r = 0; r < 6; r++) begin
         tlow   = CW'($urandom_range(0, 12));
         thigh  = CW'($urandom_range(0, 12));
         tsusta = CW'($urandom_range(0, 12));
         thdsta = CW'($urandom_range(0, 12));
         tsusto = CW'($urandom_range(0, 12));
         tsudat = CW'($urandom_range(0, 12));
         thddat = CW'($urandom_range(0, 12));
         tbuf   = CW'($urandom_range(0, 12));
         byte_v = 8'($urandom);
         run_cmd(CMD_START, 1'b0, 0, 0);
         for (int i = 7; i >= 0; i--) run_cmd(CMD_WRITE, byte_v[i], 0, 0);
         run_cmd(CMD_READ, 1'($urandom), $urandom_range(0, 6), 0);
         if ($urandom_range(0, 1) == 1) run_cmd(CMD_START, 1'b0, 0, 0);
         run_cmd(CMD_STOP, 1'b0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
